// File: rtl/regfile_write_arbiter.sv
// Two-port arbiter for the register-file write port: writeback has priority, a starvation
// guard forces a multi-cycle-unit grant. Define RFARB_STATS_EN to add conflict/forced counters.
module regfile_write_arbiter #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              mc_valid,
    output logic              mc_ready,
    input  logic [ADDR_W-1:0] mc_rd,
    input  logic [DATA_W-1:0] mc_data,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] RD,
    output logic [DATA_W-1:0] WriteData,
    output logic              mc_starved
`ifdef RFARB_STATS_EN
    ,
    output logic [31:0]       stat_conflicts,
    output logic [31:0]       stat_forced
`endif
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    typedef enum logic [0:0] {StPrio0, StForce1} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              wb_fire, mc_fire, mc_stall;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_rd;
    logic [DATA_W-1:0] wr_data;
    logic              reg_write_q;
    logic [ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StPrio0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign wb_fire  = wb_valid && wb_ready;
    assign mc_fire  = mc_valid && mc_ready;
    assign mc_stall = mc_valid && !mc_ready;

    always_comb begin
        wait_cnt_d = '0;
        if (mc_stall) begin
            wait_cnt_d = (wait_cnt_q == MAX_CNT) ? MAX_CNT : wait_cnt_q + 1'b1;
        end
        state_d = state_q;
        unique case (state_q)
            StPrio0:  if (mc_stall && wait_cnt_d == MAX_CNT) state_d = StForce1;
            StForce1: if (mc_fire || !mc_valid) state_d = StPrio0;
            default:  state_d = StPrio0;
        endcase
    end

    // Grants are held low for the whole time reset is asserted.
    always_comb begin
        wb_ready   = 1'b0;
        mc_ready   = 1'b0;
        mc_starved = 1'b0;
        if (reset) begin
            unique case (state_q)
                StPrio0: begin
                    wb_ready = wb_valid;
                    mc_ready = mc_valid && !wb_valid;
                end
                StForce1: begin
                    mc_ready   = mc_valid;
                    mc_starved = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        wr_rd   = wb_fire ? wb_rd : mc_rd;
        wr_data = wb_fire ? wb_data : mc_data;
        wr_en   = (wb_fire || mc_fire) && (wr_rd != '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            data_q      <= '0;
        end else begin
            reg_write_q <= wr_en;
            if (wr_en) begin
                rd_q   <= wr_rd;
                data_q <= wr_data;
            end
        end
    end

    assign RegWrite  = reg_write_q;
    assign RD        = rd_q;
    assign WriteData = data_q;

`ifdef RFARB_STATS_EN
    logic [31:0] conflicts_q, forced_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conflicts_q <= '0;
            forced_q    <= '0;
        end else begin
            if (wb_valid && mc_valid) conflicts_q <= conflicts_q + 32'd1;
            if (state_q == StPrio0 && state_d == StForce1) forced_q <= forced_q + 32'd1;
        end
    end

    assign stat_conflicts = conflicts_q;
    assign stat_forced    = forced_q;
`endif

endmodule
